// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: prefix codes, frame layout,
// FSM encodings and the decoded-event record.
package ps2_key_decoder_pkg;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   localparam int FRAME_BITS     = 11;
   localparam int FRAME_START    = 0;
   localparam int FRAME_DATA_LSB = 1;
   localparam int FRAME_PARITY   = 9;
   localparam int FRAME_STOP     = 10;

   typedef enum logic [1:0] {
      P_IDLE   = 2'b00,
      P_EXT    = 2'b01,
      P_BRK    = 2'b10,
      P_EXTBRK = 2'b11
   } proto_state_t;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_BITS = 1'b1
   } rx_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rpt;
   } key_event_t;

   // Keyboard housekeeping replies that never describe a key when seen unprefixed.
   function automatic logic is_ignored_code(input logic [7:0] code);
      case (code)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC,
         8'hFD, 8'hFE, 8'hFF, 8'hE1: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

   function automatic logic frame_ok(input logic [FRAME_BITS-1:0] frame);
      return !frame[FRAME_START] && frame[FRAME_STOP] &&
             (^frame[FRAME_PARITY:FRAME_DATA_LSB]);
   endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: pin synchroniser, sample-tick divider, 11-bit frame
// assembly with start/stop/parity check and an inter-edge timeout.
module ps2_key_decoder_frame_rx
   import ps2_key_decoder_pkg::*;
#(
   parameter int CLK_DIV = 250,
   parameter int TIMEOUT = 4000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

   rx_state_t                 state_q, state_d;
   logic                      clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
   logic                      dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
   logic                      prev_clk_q, prev_clk_d;
   logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
   logic [3:0]                bitcnt_q, bitcnt_d;
   logic [TO_W-1:0]           timeout_q, timeout_d;
   logic [FRAME_BITS-2:0]     shift_q, shift_d;

   logic                      tick;
   logic                      fall;
   logic                      last_bit;
   logic [FRAME_BITS-1:0]     frame_next;

   assign tick       = (div_cnt_q == DIV_LAST);
   assign fall       = tick && prev_clk_q && !clk_sync_q;
   assign last_bit   = (bitcnt_q == BIT_LAST);
   assign frame_next = {dat_sync_q, shift_q};

   // NOTE: every flop updates with <= so all of them sample pre-edge values in the same step.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q    <= RX_IDLE;
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         prev_clk_q <= 1'b1;
         div_cnt_q  <= '0;
         bitcnt_q   <= '0;
         timeout_q  <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         clk_meta_q <= clk_meta_d;
         clk_sync_q <= clk_sync_d;
         dat_meta_q <= dat_meta_d;
         dat_sync_q <= dat_sync_d;
         prev_clk_q <= prev_clk_d;
         div_cnt_q  <= div_cnt_d;
         bitcnt_q   <= bitcnt_d;
         timeout_q  <= timeout_d;
         shift_q    <= shift_d;
      end
   end

   // NOTE: each signal gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin : rx_next
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      timeout_d  = timeout_q;
      shift_d    = shift_q;
      clk_meta_d = ps2_clk;
      clk_sync_d = clk_meta_q;
      dat_meta_d = ps2_dat;
      dat_sync_d = dat_meta_q;
      div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
      prev_clk_d = tick ? clk_sync_q : prev_clk_q;

      if (fall) begin
         shift_d   = frame_next[FRAME_BITS-1:1];
         timeout_d = '0;
         if (last_bit) begin
            bitcnt_d = '0;
            state_d  = RX_IDLE;
         end else begin
            bitcnt_d = bitcnt_q + 4'd1;
            state_d  = RX_BITS;
         end
      end else if (tick && state_q == RX_BITS) begin
         // A stalled keyboard clock abandons the partial frame.
         if (timeout_q == TO_LAST) begin
            bitcnt_d  = '0;
            timeout_d = '0;
            state_d   = RX_IDLE;
         end else begin
            timeout_d = timeout_q + TO_W'(1);
         end
      end
   end

   always_comb begin : rx_out
      rx_byte    = frame_next[FRAME_DATA_LSB +: 8];
      byte_valid = fall && last_bit && frame_ok(frame_next);
      frame_err  = (fall && last_bit && !frame_ok(frame_next)) ||
                   (tick && !fall && state_q == RX_BITS && timeout_q == TO_LAST);
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix handling, per-key event strobe and a
// held/released bitmap for a configurable table of game keys.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int                      CLK_DIV   = 250,
   parameter int                      TIMEOUT   = 4000,
   parameter int                      NUM_KEYS  = 5,
   parameter logic [NUM_KEYS*8-1:0]   KEY_CODES = {8'h23, 8'h1B, 8'h1C, 8'h1D, 8'h29},
   parameter logic [NUM_KEYS-1:0]     KEY_EXT   = '0
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                PS2_KBCLK,
   input  logic                PS2_KBDAT,
   output logic [NUM_KEYS-1:0] key_down,
   output logic                event_valid,
   output logic [7:0]          event_code,
   output logic                event_ext,
   output logic                event_break,
   output logic                event_repeat,
   output logic                frame_err,
   output logic [7:0]          err_count
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;

   ps2_key_decoder_frame_rx #(
      .CLK_DIV (CLK_DIV),
      .TIMEOUT (TIMEOUT)
   ) u_frame_rx (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .ps2_clk    (PS2_KBCLK),
      .ps2_dat    (PS2_KBDAT),
      .rx_byte    (rx_byte),
      .byte_valid (rx_valid),
      .frame_err  (rx_err)
   );

   proto_state_t          state_q, state_d;
   key_event_t            event_q, event_d;
   logic                  event_valid_q, event_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic [7:0]            err_count_q, err_count_d;
   logic [NUM_KEYS-1:0]   key_down_q, key_down_d;

   logic                  emit;
   logic                  emit_ext;
   logic                  emit_brk;
   logic                  emit_rpt;
   logic [NUM_KEYS-1:0]   match;

   always_ff @(posedge CLOCK_50) begin : proto_state_reg
      if (!resetn) state_q <= P_IDLE;
      else         state_q <= state_d;
   end

   // A receive error drops any pending prefix.
   always_comb begin : proto_next
      state_d = state_q;
      if (rx_err) begin
         state_d = P_IDLE;
      end else if (rx_valid) begin
         case (state_q)
            P_IDLE: begin
               if (rx_byte == CODE_EXT)      state_d = P_EXT;
               else if (rx_byte == CODE_BRK) state_d = P_BRK;
            end
            P_EXT:   state_d = (rx_byte == CODE_BRK) ? P_EXTBRK : P_IDLE;
            default: state_d = P_IDLE;
         endcase
      end
   end

   always_comb begin : proto_out
      emit     = 1'b0;
      emit_ext = 1'b0;
      emit_brk = 1'b0;
      if (rx_valid) begin
         case (state_q)
            P_IDLE: emit = (rx_byte != CODE_EXT) && (rx_byte != CODE_BRK) &&
                           !is_ignored_code(rx_byte);
            P_EXT: begin
               emit     = (rx_byte != CODE_BRK);
               emit_ext = 1'b1;
            end
            P_BRK: begin
               emit     = 1'b1;
               emit_brk = 1'b1;
            end
            default: begin
               emit     = 1'b1;
               emit_ext = 1'b1;
               emit_brk = 1'b1;
            end
         endcase
      end
   end

   // Duplicate table entries match together, so they always agree.
   always_comb begin : key_table
      for (int i = 0; i < NUM_KEYS; i++) begin
         match[i] = (rx_byte == KEY_CODES[8*i +: 8]) && (emit_ext == KEY_EXT[i]);
      end
      emit_rpt   = !emit_brk && |(match & key_down_q);
      key_down_d = key_down_q;
      if (emit) begin
         key_down_d = emit_brk ? (key_down_q & ~match) : (key_down_q | match);
      end
   end

   always_comb begin : event_next
      event_valid_d = emit;
      event_d       = event_q;
      if (emit) begin
         event_d.code = rx_byte;
         event_d.ext  = emit_ext;
         event_d.brk  = emit_brk;
         event_d.rpt  = emit_rpt;
      end
      frame_err_d = rx_err;
      err_count_d = err_count_q;
      if (rx_err && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge CLOCK_50) begin : datapath_reg
      if (!resetn) begin
         event_q       <= '0;
         event_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         err_count_q   <= '0;
         key_down_q    <= '0;
      end else begin
         event_q       <= event_d;
         event_valid_q <= event_valid_d;
         frame_err_q   <= frame_err_d;
         err_count_q   <= err_count_d;
         key_down_q    <= key_down_d;
      end
   end

   assign key_down     = key_down_q;
   assign event_valid  = event_valid_q;
   assign event_code   = event_q.code;
   assign event_ext    = event_q.ext;
   assign event_break  = event_q.brk;
   assign event_repeat = event_q.rpt;
   assign frame_err    = frame_err_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized PS/2 traffic checked against a byte-level
// behavioural model of prefix decoding and key state.
module tb_ps2_key_decoder;

   localparam int               NK    = 5;
   localparam logic [NK*8-1:0]  CODES = {8'h23, 8'h1D, 8'h1C, 8'h75, 8'h29};
   localparam logic [NK-1:0]    EXTS  = 5'b00010;

   logic          CLOCK_50  = 1'b0;
   logic          resetn    = 1'b0;
   logic          PS2_KBCLK = 1'b1;
   logic          PS2_KBDAT = 1'b1;
   logic [NK-1:0] key_down;
   logic          event_valid;
   logic [7:0]    event_code;
   logic          event_ext;
   logic          event_break;
   logic          event_repeat;
   logic          frame_err;
   logic [7:0]    err_count;

   ps2_key_decoder #(
      .CLK_DIV   (4),
      .TIMEOUT   (50),
      .NUM_KEYS  (NK),
      .KEY_CODES (CODES),
      .KEY_EXT   (EXTS)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .resetn       (resetn),
      .PS2_KBCLK    (PS2_KBCLK),
      .PS2_KBDAT    (PS2_KBDAT),
      .key_down     (key_down),
      .event_valid  (event_valid),
      .event_code   (event_code),
      .event_ext    (event_ext),
      .event_break  (event_break),
      .event_repeat (event_repeat),
      .frame_err    (frame_err),
      .err_count    (err_count)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rpt;
   } ev_t;

   // Monitor: records every event strobe and counts error strobes.
   ev_t mon_buf [0:511];
   int  mon_wr   = 0;
   int  err_seen = 0;

   always @(negedge CLOCK_50) begin
      if (resetn) begin
         if (event_valid) begin
            mon_buf[mon_wr % 512] = {event_code, event_ext, event_break, event_repeat};
            mon_wr++;
         end
         if (frame_err) err_seen++;
      end
   end

   // Reference model state.
   ev_t        exp_q[$];
   logic [7:0] pfx[$];
   bit         held[logic [8:0]];
   int         err_exp  = 0;
   int         err_base = 0;
   int         mon_rd   = 0;
   int         errors   = 0;
   int         checks   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_table(input logic ext, input logic [7:0] code);
      for (int i = 0; i < NK; i++)
         if (CODES[8*i +: 8] == code && EXTS[i] == ext) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit ignored(input logic [7:0] b);
      return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hE1};
   endfunction

   task automatic model_byte(input logic [7:0] b);
      bit has_e0 = 1'b0;
      bit has_f0 = 1'b0;
      ev_t e;
      foreach (pfx[k]) begin
         if (pfx[k] == 8'hE0) has_e0 = 1'b1;
         if (pfx[k] == 8'hF0) has_f0 = 1'b1;
      end
      if (b == 8'hE0 && pfx.size() == 0) pfx.push_back(b);
      else if (b == 8'hF0 && !has_f0) pfx.push_back(b);
      else if (pfx.size() == 0 && ignored(b)) begin end
      else begin
         e.code = b;
         e.ext  = has_e0;
         e.brk  = has_f0;
         e.rpt  = !has_f0 && in_table(has_e0, b) &&
                  held.exists({has_e0, b}) && held[{has_e0, b}];
         held[{has_e0, b}] = !has_f0;
         exp_q.push_back(e);
         pfx.delete();
      end
   endtask

   task automatic model_err();
      pfx.delete();
      err_exp++;
   endtask

   task automatic model_reset();
      pfx.delete();
      held.delete();
      exp_q.delete();
      err_exp  = 0;
      err_base = err_seen;
      mon_rd   = mon_wr;
   endtask

   function automatic logic [NK-1:0] exp_keys();
      logic [NK-1:0] k = '0;
      for (int i = 0; i < NK; i++)
         if (held.exists({EXTS[i], CODES[8*i +: 8]})) k[i] = held[{EXTS[i], CODES[8*i +: 8]}];
      return k;
   endfunction

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int nbits, input int half);
      for (int i = 0; i < nbits; i++) begin
         PS2_KBDAT = f[i];
         repeat (half) @(negedge CLOCK_50);
         PS2_KBCLK = 1'b0;
         repeat (half) @(negedge CLOCK_50);
         PS2_KBCLK = 1'b1;
      end
      repeat (half) @(negedge CLOCK_50);
      PS2_KBDAT = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input int half, input bit bad_par,
                            input bit bad_stop, input int idle);
      send_bits(mk_frame(d, bad_par, bad_stop), 11, half);
      repeat (idle) @(negedge CLOCK_50);
      if (bad_par || bad_stop) model_err();
      else model_byte(d);
   endtask

   task automatic check_state(input string tag);
      ev_t got;
      ev_t want;
      check({tag, "_event_count"}, 32'(mon_wr - mon_rd), 32'(exp_q.size()));
      while (exp_q.size() > 0 && mon_rd < mon_wr) begin
         want = exp_q.pop_front();
         got  = mon_buf[mon_rd % 512];
         mon_rd++;
         check({tag, "_event"}, 32'(got), 32'(want));
      end
      exp_q.delete();
      mon_rd = mon_wr;
      check({tag, "_key_down"}, 32'(key_down), 32'(exp_keys()));
      check({tag, "_err_strobes"}, 32'(err_seen - err_base), 32'(err_exp));
      check({tag, "_err_count"}, 32'(err_count), (err_exp > 255) ? 32'd255 : 32'(err_exp));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_key_down"},     32'(key_down),     32'd0);
      check({tag, "_event_valid"},  32'(event_valid),  32'd0);
      check({tag, "_event_code"},   32'(event_code),   32'd0);
      check({tag, "_event_ext"},    32'(event_ext),    32'd0);
      check({tag, "_event_break"},  32'(event_break),  32'd0);
      check({tag, "_event_repeat"}, 32'(event_repeat), 32'd0);
      check({tag, "_frame_err"},    32'(frame_err),    32'd0);
      check({tag, "_err_count"},    32'(err_count),    32'd0);
   endtask

   logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h29, 8'h75, 8'h1C, 8'h1D, 8'h23, 8'hAA, 8'h00, 8'h44};

   initial begin
      logic [7:0] b;
      repeat (4) @(negedge CLOCK_50);
      check_reset_outputs("reset");
      resetn = 1'b1;
      repeat (10) @(negedge CLOCK_50);

      send_byte(8'h29, 80, 0, 0, 20);
      check_state("make_29");
      send_byte(8'hF0, 80, 0, 0, 20);
      check_state("prefix_f0");
      send_byte(8'h29, 16, 0, 0, 20);
      check_state("break_29");

      send_byte(8'hE0, 16, 0, 0, 20);
      send_byte(8'h75, 16, 0, 0, 20);
      check_state("ext_make_75");
      send_byte(8'hE0, 16, 0, 0, 20);
      send_byte(8'hF0, 16, 0, 0, 20);
      send_byte(8'h75, 16, 0, 0, 20);
      check_state("ext_break_75");

      send_byte(8'h1D, 16, 0, 0, 20);
      send_byte(8'h1D, 16, 0, 0, 20);
      check_state("typematic_1d");

      send_byte(8'h29, 16, 1, 0, 20);
      check_state("bad_parity");
      send_byte(8'h29, 16, 0, 1, 20);
      check_state("bad_stop");

      send_bits(mk_frame(8'h55, 0, 0), 6, 16);
      repeat (300) @(negedge CLOCK_50);
      model_err();
      check_state("timeout");
      send_byte(8'h1C, 16, 0, 0, 20);
      check_state("after_timeout_1c");

      send_byte(8'hE0, 16, 0, 0, 20);
      send_byte(8'h1C, 16, 1, 0, 20);
      send_byte(8'h1C, 16, 0, 0, 20);
      check_state("prefix_dropped");

      for (int n = 0; n < 25; n++) begin
         int k = $urandom_range(0, 9);
         b = (k == 9) ? 8'($urandom) : pool[k];
         send_byte(b, 16, ($urandom_range(0, 7) == 0), 1'b0, 20);
         check_state("random");
      end

      // Reset in the middle of bit 5 while the keyboard clock is low.
      send_bits(mk_frame(8'h23, 0, 0), 4, 16);
      PS2_KBDAT = 1'b1;
      repeat (16) @(negedge CLOCK_50);
      PS2_KBCLK = 1'b0;
      repeat (8) @(negedge CLOCK_50);
      resetn = 1'b0;
      repeat (8) @(negedge CLOCK_50);
      PS2_KBCLK = 1'b1;
      repeat (4) @(negedge CLOCK_50);
      check_reset_outputs("mid_frame_reset");
      resetn = 1'b1;
      model_reset();
      repeat (20) @(negedge CLOCK_50);
      send_byte(8'h29, 16, 0, 0, 20);
      check_state("after_reset_29");

      for (int n = 0; n < 300; n++) begin
         send_byte(8'($urandom), 6, 1, 0, 4);
         if (err_exp == 254 || err_exp == 255) check_state("sat_edge");
      end
      check_state("saturated");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
